// File: rtl/ddr3_frame_reader_if.sv
`default_nettype none
// ============================================================================
// ddr3_frame_reader_if : Avalon-MM burst-read port plus pixel FIFO write port
// Revision: 1.0
// ============================================================================
interface ddr3_frame_reader_if;
  logic [25:0] avm_address;
  logic        avm_read;
  logic [6:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [9:0]  pix_fifo_free;
  logic        pix_wr;
  logic [31:0] pix_data;

  modport master (
    output avm_address, avm_read, avm_burstcount,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  pix_fifo_free,
    output pix_wr, pix_data
  );

  modport slave (
    input  avm_address, avm_read, avm_burstcount,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    output pix_fifo_free,
    input  pix_wr, pix_data
  );
endinterface
`default_nettype wire

// File: rtl/ddr3_frame_reader.sv
`default_nettype none
// ============================================================================
// ddr3_frame_reader : double-buffered frame scan-out via Avalon-MM bursts
// Revision: 1.0
// ============================================================================
module ddr3_frame_reader #(
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 307200
) (
  input  logic                 ddr3_clk,
  input  logic                 ddr3_reset,
  input  logic                 frame_start,
  input  logic                 ddr3_rd_buffer0_empty,
  input  logic                 ddr3_rd_buffer1_empty,
  input  logic [25:0]          ddr3_buffer0_offset,
  input  logic [25:0]          ddr3_buffer1_offset,
  output logic                 clear_buffer0,
  output logic                 clear_buffer1,
  ddr3_frame_reader_if.master  bus,
  output logic                 cur_buf,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0]  c_burst      = 7'(BURST_LEN);
  localparam logic [9:0]  c_burst_free = 10'(BURST_LEN);
  localparam logic [20:0] c_frame      = 21'(FRAME_WORDS);

  state_t      state_q, state_d;
  logic        cur_buf_q, cur_buf_d;
  logic [19:0] word_cnt_q, word_cnt_d;
  logic [6:0]  beat_cnt_q, beat_cnt_d;
  logic [25:0] base_q, base_d;
  logic [25:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        pix_wr_q, pix_wr_d;
  logic [31:0] pix_data_q, pix_data_d;
  logic        clear0_q, clear0_d;
  logic        clear1_q, clear1_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;

  logic        other_full;
  logic        fifo_ok;
  logic [20:0] word_next;

  assign other_full = cur_buf_q ? ~ddr3_rd_buffer0_empty : ~ddr3_rd_buffer1_empty;
  assign fifo_ok    = (bus.pix_fifo_free >= c_burst_free);
  assign word_next  = {1'b0, word_cnt_q} + 21'(BURST_LEN);

  always_comb begin
    state_d    = state_q;
    cur_buf_d  = cur_buf_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    base_d     = base_q;
    addr_d     = addr_q;
    read_d     = read_q;
    pix_wr_d   = 1'b0;
    pix_data_d = pix_data_q;
    clear0_d   = 1'b0;
    clear1_d   = 1'b0;
    done_d     = 1'b0;
    overrun_d  = overrun_q | (frame_start & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          // Switching to the freshly filled buffer hands the old one back to the CPU.
          if (other_full) begin
            cur_buf_d = ~cur_buf_q;
            clear0_d  = ~cur_buf_q;
            clear1_d  = cur_buf_q;
          end
          base_d     = cur_buf_d ? ddr3_buffer1_offset : ddr3_buffer0_offset;
          word_cnt_d = '0;
          beat_cnt_d = '0;
          addr_d     = base_d;
          read_d     = fifo_ok;
          state_d    = REQ;
        end
      end

      REQ: begin
        if (read_q) begin
          if (!bus.avm_waitrequest) begin
            read_d  = 1'b0;
            state_d = DATA;
          end
        end else if (fifo_ok) begin
          read_d = 1'b1;
          addr_d = base_q + 26'(word_cnt_q);
        end
      end

      DATA: begin
        if (bus.avm_readdatavalid) begin
          pix_wr_d   = 1'b1;
          pix_data_d = bus.avm_readdata;
          if (beat_cnt_q == c_burst - 7'd1) begin
            beat_cnt_d = '0;
            word_cnt_d = word_next[19:0];
            state_d    = (word_next == c_frame) ? DONE : REQ;
          end else begin
            beat_cnt_d = beat_cnt_q + 7'd1;
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk) begin
    if (ddr3_reset) begin
      state_q    <= IDLE;
      cur_buf_q  <= 1'b0;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      pix_wr_q   <= 1'b0;
      pix_data_q <= '0;
      clear0_q   <= 1'b0;
      clear1_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_buf_q  <= cur_buf_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      pix_wr_q   <= pix_wr_d;
      pix_data_q <= pix_data_d;
      clear0_q   <= clear0_d;
      clear1_q   <= clear1_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_burstcount = c_burst;
  assign bus.pix_wr         = pix_wr_q;
  assign bus.pix_data       = pix_data_q;
  assign clear_buffer0      = clear0_q;
  assign clear_buffer1      = clear1_q;
  assign cur_buf            = cur_buf_q;
  // The done pulse cycle still counts as busy so busy drops one cycle after it.
  assign busy               = (state_q != IDLE) | done_q;
  assign frame_done         = done_q;
  assign overrun            = overrun_q;

endmodule
`default_nettype wire

// File: doc/ddr3_frame_reader.md
# ddr3_frame_reader

Double-buffered frame scan-out controller in the DDR3 clock domain. On each display frame request it selects which of the two DDR3 frame buffers to read, issues fixed-length Avalon-MM burst reads from that buffer's base offset, and forwards the returned words to the pixel FIFO. It returns a buffer to the CPU by pulsing `clear_buffer0`/`clear_buffer1`, which drives the buffer-full flags in the DDR3 register block.

## Interface
- `BURST_LEN`, 16: words per Avalon burst; power of two, 1..64.
- `FRAME_WORDS`, 307200: 32-bit words per frame; integer multiple of `BURST_LEN`, < 2^20.
- `ddr3_clk`  in  1  single clock for all logic.
- `ddr3_reset`  in  1  reset; synchronous, active-high.
- `frame_start`  in  1  one-cycle request to scan out one frame.
- `ddr3_rd_buffer0_empty`, `ddr3_rd_buffer1_empty`  in  1 each  buffer-full flags, inverted (1 = no new frame).
- `ddr3_buffer0_offset`, `ddr3_buffer1_offset`  in  26 each  buffer base word addresses.
- `clear_buffer0`, `clear_buffer1`  out  1 each  one-cycle buffer release pulses.
- `avm_address`  out  26  burst start word address.
- `avm_read`  out  1  read request.
- `avm_burstcount`  out  7  constant `BURST_LEN`.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  read data.
- `avm_readdatavalid`  in  1  read data beat valid.
- `pix_fifo_free`  in  10  free entries in the pixel FIFO.
- `pix_wr`  out  1  pixel FIFO write strobe.
- `pix_data`  out  32  pixel FIFO write data.
- `cur_buf`  out  1  buffer currently or last scanned.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after the last beat of a frame.
- `overrun`  out  1  sticky flag: `frame_start` received while busy; cleared only by reset.

## Operation
- Reset values: state IDLE, `cur_buf`=0, word count 0, and all outputs 0 (address 0, `avm_read`, `pix_wr`, pulses, `busy`, `overrun`). `avm_burstcount` is constant `BURST_LEN`.
- States: IDLE, REQ, DATA, DONE.
- IDLE, `frame_start`=1: buffer selection.
  - Let o = !`cur_buf`. If buffer o is full (its empty flag is 0), set `cur_buf` to o and pulse `clear_<old cur_buf>`. This releases the previously displayed buffer.
  - Otherwise keep `cur_buf` and do not pulse a clear; the same frame repeats.
  - If both buffers are full, the other buffer is chosen.
  - The first frame after reset reads buffer 0 unless buffer 1 is full.
  - Word count is set to 0 and the state moves to REQ.
- REQ:
  - When `pix_fifo_free` >= `BURST_LEN`, drive `avm_read`=1 with `avm_address` = selected offset + word count, truncated mod 2^26.
  - Address, burstcount and read are held stable while `avm_waitrequest`=1.
  - The request is accepted in the first cycle with `avm_waitrequest`=0; the state then moves to DATA and `avm_read` drops next cycle.
- DATA:
  - Each `avm_readdatavalid` beat increments the beat counter and is forwarded to the pixel FIFO.
  - After `BURST_LEN` beats, word count += `BURST_LEN`.
  - If word count = `FRAME_WORDS`, go to DONE; otherwise go to REQ.
  - Only one burst is outstanding at any time.
- DONE: pulse `frame_done` and return to IDLE.
- `busy` = 1 in REQ, DATA and DONE.
- Offsets are sampled once, at selection. CPU updates to the offsets mid-frame take effect on the next frame.
- `frame_start` outside IDLE is ignored and sets `overrun`.
- `avm_readdatavalid` outside DATA is ignored (stale beats after reset are discarded).
- Reset asserted mid-burst: the block returns to reset values on the next edge and drops `avm_read`; no clear or done pulse is issued.

## Timing
- `frame_start` high in cycle T (IDLE):
  - `cur_buf`, the clear pulse and state REQ are visible in T+1.
  - `avm_read` is high in T+1 if FIFO space allows.
- `avm_read` held from assertion through the cycle with `avm_waitrequest`=0; low the following cycle.
- Pixel path: `avm_readdatavalid`/`avm_readdata` in cycle C give `pix_wr`/`pix_data` in C+1 (registered, 1-cycle latency).
- Last beat of a burst in cycle C:
  - Next burst: state REQ in C+1, next `avm_read` no earlier than C+1.
  - Last burst of the frame: `frame_done` high in C+2, `busy` low in C+3.
- Clear pulses are exactly one cycle; at most one per frame.

## Test plan
- Reset, both buffers empty, single `frame_start`, `FRAME_WORDS`=32, `BURST_LEN`=16, offset0=0x100:
  - 2 bursts at 0x100 and 0x110.
  - 32 `pix_wr` with data matching the slave.
  - No clear pulse; one `frame_done`.
- Buffer1 full, offset1=0x3FFFFF8, `cur_buf`=0, then `frame_start`:
  - `clear_buffer0` pulses once and `cur_buf`=1.
  - Second burst address wraps to 0x0000008.
- Both buffers full with `cur_buf`=1, then `frame_start`:
  - Buffer 0 selected; `clear_buffer1` pulses; `clear_buffer0` stays 0.
- Slave holds `avm_waitrequest` for 5 cycles, with `pix_fifo_free`=8 and then 20:
  - No `avm_read` while free < 16.
  - Address and read stable during the stall; exactly one request accepted.
- `frame_start` during DATA, then `ddr3_reset` pulsed mid-burst with trailing `avm_readdatavalid` beats:
  - `overrun` sets on the extra `frame_start`.
  - After reset, all outputs are 0 and the trailing beats produce no `pix_wr`.
